// File: rtl/alu_ctl_pkg.sv
// Shared encodings for the BPF ALU controller: instruction classes, jump
// conditions, controller states and the ALU op code forced for compares.
package alu_ctl_pkg;

  typedef enum logic [1:0] {
    OPC_ALU  = 2'd0,
    OPC_JMP  = 2'd1,
    OPC_RSV2 = 2'd2,
    OPC_RSV3 = 2'd3
  } op_class_e;

  typedef enum logic [2:0] {
    JC_JA   = 3'd0,
    JC_JEQ  = 3'd1,
    JC_JGT  = 3'd2,
    JC_JGE  = 3'd3,
    JC_JSET = 3'd4
  } jcond_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [3:0] ALU_SEL_SUB = 4'd1;

  // Unconditional jumps and reserved classes finish without touching the ALU.
  function automatic logic needs_alu(input logic [1:0] cls, input logic [2:0] jc);
    return (cls == OPC_ALU) || ((cls == OPC_JMP) && (jc != JC_JA));
  endfunction

endpackage

// File: rtl/alu_ctl_branch_eval.sv
// Combinational jump-condition evaluator: picks the ALU flag named by jcond.
module branch_eval
  import alu_ctl_pkg::*;
(
  input  logic [2:0] jcond,
  input  logic       eq,
  input  logic       gt,
  input  logic       ge,
  input  logic       set,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (jcond)
      JC_JA:   taken = 1'b1;
      JC_JEQ:  taken = eq;
      JC_JGT:  taken = gt;
      JC_JGE:  taken = ge;
      JC_JSET: taken = set;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctl.sv
// Accumulator-side controller for a BPF-style core: accepts decoded ALU/JMP
// instructions, drives an external ALU and reports accumulator/branch results.
module alu_ctl
  import alu_ctl_pkg::*;
#(
  parameter int OFF_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_vld,
  output logic             instr_rdy,
  input  logic [1:0]       op_class,
  input  logic [3:0]       op_sel,
  input  logic [2:0]       jcond,
  input  logic             src_x,
  input  logic [31:0]      imm,
  input  logic [31:0]      x_reg,
  input  logic [OFF_W-1:0] jt,
  input  logic [OFF_W-1:0] jf,
  input  logic             acc_wr,
  input  logic [31:0]      acc_din,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [3:0]       ALU_sel,
  output logic             ALU_en,
  output logic             ALU_ack,
  input  logic [31:0]      ALU_out,
  input  logic             eq,
  input  logic             gt,
  input  logic             ge,
  input  logic             set,
  input  logic             ALU_vld,
  output logic [31:0]      acc,
  output logic             done,
  output logic             br_vld,
  output logic [OFF_W-1:0] br_off
);

  state_e           state;
  logic [1:0]       class_q;
  logic [3:0]       sel_q;
  logic [2:0]       jcond_q;
  logic             src_x_q;
  logic [31:0]      imm_q;
  logic [31:0]      x_q;
  logic [OFF_W-1:0] jt_q;
  logic [OFF_W-1:0] jf_q;
  logic             alu_en_q;
  logic             done_q;
  logic             br_vld_q;
  logic [OFF_W-1:0] br_off_q;
  logic             taken;
  logic             complete;
  logic             jmp_q;

  branch_eval u_branch_eval (
    .jcond (jcond_q),
    .eq    (eq),
    .gt    (gt),
    .ge    (ge),
    .set   (set),
    .taken (taken)
  );

  assign instr_rdy = (state == S_IDLE) && !acc_wr && !rst;
  assign complete  = (state == S_WAIT) && ALU_vld && !rst;
  assign jmp_q     = (class_q == OPC_JMP);

  assign A       = acc;
  assign B       = src_x_q ? x_q : imm_q;
  assign ALU_sel = jmp_q ? ALU_SEL_SUB : sel_q;
  assign ALU_en  = alu_en_q;
  assign ALU_ack = complete;

  // ISSUE-cycle results are registered; WAIT-cycle results follow ALU_vld directly.
  assign done   = done_q | complete;
  assign br_vld = br_vld_q | (complete && jmp_q);
  assign br_off = br_off_q | ((complete && jmp_q) ? (taken ? jt_q : jf_q) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      class_q  <= '0;
      sel_q    <= '0;
      jcond_q  <= '0;
      src_x_q  <= 1'b0;
      imm_q    <= '0;
      x_q      <= '0;
      jt_q     <= '0;
      jf_q     <= '0;
      alu_en_q <= 1'b0;
      done_q   <= 1'b0;
      br_vld_q <= 1'b0;
      br_off_q <= '0;
    end else begin
      alu_en_q <= 1'b0;
      done_q   <= 1'b0;
      br_vld_q <= 1'b0;
      br_off_q <= '0;
      case (state)
        S_IDLE: begin
          if (acc_wr) begin
            acc <= acc_din;
          end else if (instr_vld) begin
            class_q <= op_class;
            sel_q   <= op_sel;
            jcond_q <= jcond;
            src_x_q <= src_x;
            imm_q   <= imm;
            x_q     <= x_reg;
            jt_q    <= jt;
            jf_q    <= jf;
            state   <= S_ISSUE;
            if (needs_alu(op_class, jcond)) begin
              alu_en_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
              if (op_class == OPC_JMP) begin
                br_vld_q <= 1'b1;
                br_off_q <= jt;
              end
            end
          end
        end
        S_ISSUE: begin
          state <= needs_alu(class_q, jcond_q) ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (ALU_vld) begin
            if (!jmp_q) acc <= ALU_out;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctl.sv
// Self-checking bench for alu_ctl: directed vector table, randomized
// instructions against a reference model, and reset/acc_wr corner sequences.
module tb_alu_ctl;

  localparam int OFF_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_vld;
  logic             instr_rdy;
  logic [1:0]       op_class;
  logic [3:0]       op_sel;
  logic [2:0]       jcond;
  logic             src_x;
  logic [31:0]      imm;
  logic [31:0]      x_reg;
  logic [OFF_W-1:0] jt;
  logic [OFF_W-1:0] jf;
  logic             acc_wr;
  logic [31:0]      acc_din;
  logic [31:0]      A;
  logic [31:0]      B;
  logic [3:0]       ALU_sel;
  logic             ALU_en;
  logic             ALU_ack;
  logic [31:0]      ALU_out;
  logic             eq;
  logic             gt;
  logic             ge;
  logic             set;
  logic             ALU_vld;
  logic [31:0]      acc;
  logic             done;
  logic             br_vld;
  logic [OFF_W-1:0] br_off;

  alu_ctl #(.OFF_W(OFF_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr_vld (instr_vld),
    .instr_rdy (instr_rdy),
    .op_class  (op_class),
    .op_sel    (op_sel),
    .jcond     (jcond),
    .src_x     (src_x),
    .imm       (imm),
    .x_reg     (x_reg),
    .jt        (jt),
    .jf        (jf),
    .acc_wr    (acc_wr),
    .acc_din   (acc_din),
    .A         (A),
    .B         (B),
    .ALU_sel   (ALU_sel),
    .ALU_en    (ALU_en),
    .ALU_ack   (ALU_ack),
    .ALU_out   (ALU_out),
    .eq        (eq),
    .gt        (gt),
    .ge        (ge),
    .set       (set),
    .ALU_vld   (ALU_vld),
    .acc       (acc),
    .done      (done),
    .br_vld    (br_vld),
    .br_off    (br_off)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cls;
    logic [3:0]  sel;
    logic [2:0]  jc;
    logic        srcx;
    logic [31:0] imm;
    logic [31:0] x;
    logic [7:0]  jt;
    logic [7:0]  jf;
    int          delay;
    logic        preload;
    logic [31:0] accIn;
    logic [31:0] expAcc;
    logic        expBrVld;
    logic [7:0]  expBrOff;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          enCount = 0;
  int          ackCount = 0;
  logic [31:0] accModel = '0;
  vec_t        tbl[12];

  always @(posedge clk) begin
    if (ALU_en) enCount++;
    if (ALU_ack) ackCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference ALU used as the stub on the response side.
  function automatic logic [31:0] aluRef(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      default: return b;
    endcase
  endfunction

  function automatic logic condTaken(input logic [2:0] jc, input logic [31:0] a, input logic [31:0] b);
    case (jc)
      3'd0: return 1'b1;
      3'd1: return a == b;
      3'd2: return a > b;
      3'd3: return a >= b;
      3'd4: return (a & b) != 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic vec_t mkVec(input logic [1:0] cls, input logic [3:0] sel, input logic [2:0] jc,
                                 input logic srcx, input logic [31:0] immV, input logic [31:0] xV,
                                 input logic [7:0] jtV, input logic [7:0] jfV, input int delay,
                                 input logic preload, input logic [31:0] accIn, input logic [31:0] expAcc,
                                 input logic expBrVld, input logic [7:0] expBrOff);
    vec_t v;
    v.cls = cls; v.sel = sel; v.jc = jc; v.srcx = srcx; v.imm = immV; v.x = xV;
    v.jt = jtV; v.jf = jfV; v.delay = delay; v.preload = preload; v.accIn = accIn;
    v.expAcc = expAcc; v.expBrVld = expBrVld; v.expBrOff = expBrOff;
    return v;
  endfunction

  // Fills the expected outcome of v from the current accumulator model.
  task automatic predict(inout vec_t v);
    logic [31:0] b;
    b = v.srcx ? v.x : v.imm;
    v.expAcc   = (v.cls == 2'd0) ? aluRef(v.sel, accModel, b) : accModel;
    v.expBrVld = (v.cls == 2'd1);
    v.expBrOff = (v.cls != 2'd1) ? 8'd0 : (condTaken(v.jc, accModel, b) ? v.jt : v.jf);
  endtask

  task automatic loadAcc(input logic [31:0] val);
    @(negedge clk);
    acc_wr = 1'b1; acc_din = val; instr_vld = 1'($urandom_range(0, 1));
    #1 checkOutput("rdy_during_acc_wr", 32'(instr_rdy), 32'd0);
    @(negedge clk);
    acc_wr = 1'b0; instr_vld = 1'b0;
    #1 checkOutput("acc_after_load", acc, val);
    accModel = val;
  endtask

  task automatic applyStimulus(input vec_t v);
    int          en0;
    int          ack0;
    logic        needAlu;
    logic [31:0] bExp;
    logic [3:0]  selExp;
    en0 = enCount; ack0 = ackCount;
    needAlu = (v.cls == 2'd0) || (v.cls == 2'd1 && v.jc != 3'd0);
    bExp    = v.srcx ? v.x : v.imm;
    selExp  = (v.cls == 2'd1) ? 4'd1 : v.sel;

    @(negedge clk);
    instr_vld = 1'b1; op_class = v.cls; op_sel = v.sel; jcond = v.jc; src_x = v.srcx;
    imm = v.imm; x_reg = v.x; jt = v.jt; jf = v.jf; acc_wr = 1'b0; ALU_vld = 1'b0;
    #1 checkOutput("rdy_idle", 32'(instr_rdy), 32'd1);

    // ISSUE cycle: scramble inputs to show the instruction was latched.
    @(negedge clk);
    instr_vld = 1'b0; op_class = 2'($urandom); op_sel = 4'($urandom); jcond = 3'($urandom);
    src_x = 1'($urandom); imm = $urandom; x_reg = $urandom; jt = 8'($urandom); jf = 8'($urandom);
    acc_wr = 1'($urandom_range(0, 1)); acc_din = $urandom;
    #1;
    checkOutput("rdy_issue", 32'(instr_rdy), 32'd0);
    if (needAlu) begin
      checkOutput("alu_en_issue", 32'(ALU_en), 32'd1);
      checkOutput("A_issue", A, accModel);
      checkOutput("B_issue", B, bExp);
      checkOutput("sel_issue", 32'(ALU_sel), 32'(selExp));
      checkOutput("done_issue", 32'(done), 32'd0);
      for (int k = 0; k <= v.delay; k++) begin
        @(negedge clk);
        acc_wr = 1'($urandom_range(0, 1)); acc_din = $urandom;
        if (k == v.delay) begin
          ALU_vld = 1'b1;
          ALU_out = aluRef(selExp, accModel, bExp);
          eq = (accModel == bExp); gt = (accModel > bExp); ge = (accModel >= bExp);
          set = ((accModel & bExp) != 0);
          #1;
          checkOutput("ack_complete", 32'(ALU_ack), 32'd1);
          checkOutput("done_complete", 32'(done), 32'd1);
          checkOutput("br_vld_complete", 32'(br_vld), 32'(v.expBrVld));
          checkOutput("br_off_complete", 32'(br_off), 32'(v.expBrOff));
        end else begin
          ALU_vld = 1'b0; ALU_out = $urandom;
          #1;
          checkOutput("alu_en_wait", 32'(ALU_en), 32'd0);
          checkOutput("ack_wait", 32'(ALU_ack), 32'd0);
          checkOutput("done_wait", 32'(done), 32'd0);
          checkOutput("rdy_wait", 32'(instr_rdy), 32'd0);
          checkOutput("B_wait", B, bExp);
        end
      end
    end else begin
      checkOutput("alu_en_direct", 32'(ALU_en), 32'd0);
      checkOutput("done_direct", 32'(done), 32'd1);
      checkOutput("br_vld_direct", 32'(br_vld), 32'(v.expBrVld));
      checkOutput("br_off_direct", 32'(br_off), 32'(v.expBrOff));
    end

    @(negedge clk);
    ALU_vld = 1'b0; acc_wr = 1'b0;
    #1 checkOutput("result", acc, v.expAcc);
    checkOutput("done_pulse", 32'(done), 32'd0);
    checkOutput("br_vld_pulse", 32'(br_vld), 32'd0);
    checkOutput("br_off_idle", 32'(br_off), 32'd0);
    checkOutput("rdy_back", 32'(instr_rdy), 32'd1);
    checkOutput("alu_en_count", 32'(enCount - en0), 32'(needAlu));
    checkOutput("ack_count", 32'(ackCount - ack0), 32'(needAlu));
    accModel = v.expAcc;
  endtask

  initial begin
    vec_t v;
    int   ack0;
    rst = 1'b1; instr_vld = 1'b0; op_class = '0; op_sel = '0; jcond = '0; src_x = 1'b0;
    imm = '0; x_reg = '0; jt = '0; jf = '0; acc_wr = 1'b0; acc_din = '0;
    ALU_out = '0; eq = 1'b0; gt = 1'b0; ge = 1'b0; set = 1'b0; ALU_vld = 1'b0;

    repeat (2) @(negedge clk);
    instr_vld = 1'b1;
    #1 checkOutput("rdy_in_reset", 32'(instr_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0; instr_vld = 1'b0;
    #1 checkOutput("reset_acc", acc, 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_br_vld", 32'(br_vld), 32'd0);
    checkOutput("reset_br_off", 32'(br_off), 32'd0);
    checkOutput("reset_alu_en", 32'(ALU_en), 32'd0);
    checkOutput("reset_ack", 32'(ALU_ack), 32'd0);
    checkOutput("reset_B", B, 32'd0);
    checkOutput("reset_sel", 32'(ALU_sel), 32'd0);
    checkOutput("reset_rdy", 32'(instr_rdy), 32'd1);

    //                cls   sel   jc    sx    imm            x     jt     jf     dly pre  accIn          expAcc         bv    boff
    tbl[0]  = mkVec(2'd0, 4'd0, 3'd0, 1'b0, 32'd3,        32'd0, 8'd0,  8'd0,  0, 1'b1, 32'd5,        32'd8,         1'b0, 8'd0);
    tbl[1]  = mkVec(2'd1, 4'd0, 3'd2, 1'b0, 32'd7,        32'd0, 8'd4,  8'd9,  1, 1'b1, 32'd10,       32'd10,        1'b1, 8'd4);
    tbl[2]  = mkVec(2'd1, 4'd0, 3'd2, 1'b0, 32'd12,       32'd0, 8'd4,  8'd9,  0, 1'b0, 32'd0,        32'd10,        1'b1, 8'd9);
    tbl[3]  = mkVec(2'd1, 4'd0, 3'd0, 1'b0, 32'd0,        32'd0, 8'd3,  8'd7,  0, 1'b0, 32'd0,        32'd10,        1'b1, 8'd3);
    tbl[4]  = mkVec(2'd0, 4'd1, 3'd0, 1'b1, 32'd99,       32'd3, 8'd0,  8'd0,  5, 1'b0, 32'd0,        32'd7,         1'b0, 8'd0);
    tbl[5]  = mkVec(2'd2, 4'd0, 3'd1, 1'b0, 32'd5,        32'd0, 8'd5,  8'd6,  0, 1'b0, 32'd0,        32'd7,         1'b0, 8'd0);
    tbl[6]  = mkVec(2'd3, 4'd2, 3'd0, 1'b0, 32'd5,        32'd0, 8'd5,  8'd6,  0, 1'b0, 32'd0,        32'd7,         1'b0, 8'd0);
    tbl[7]  = mkVec(2'd0, 4'd0, 3'd0, 1'b0, 32'd2,        32'd0, 8'd0,  8'd0,  2, 1'b1, 32'hFFFF_FFFF, 32'd1,        1'b0, 8'd0);
    tbl[8]  = mkVec(2'd1, 4'd0, 3'd1, 1'b1, 32'd0,        32'd1, 8'h11, 8'h12, 0, 1'b0, 32'd0,        32'd1,         1'b1, 8'h11);
    tbl[9]  = mkVec(2'd1, 4'd0, 3'd4, 1'b0, 32'd2,        32'd0, 8'h21, 8'h22, 1, 1'b0, 32'd0,        32'd1,         1'b1, 8'h22);
    tbl[10] = mkVec(2'd1, 4'd0, 3'd6, 1'b0, 32'd0,        32'd0, 8'h31, 8'h33, 0, 1'b0, 32'd0,        32'd1,         1'b1, 8'h33);
    tbl[11] = mkVec(2'd0, 4'd2, 3'd0, 1'b0, 32'h0000_F0F0, 32'd0, 8'd0, 8'd0,  3, 1'b1, 32'h1234_5678, 32'h0000_5070, 1'b0, 8'd0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].preload) loadAcc(tbl[i].accIn);
      applyStimulus(tbl[i]);
    end

    for (int i = 0; i < 40; i++) begin
      int pick;
      if ($urandom_range(0, 3) == 0) loadAcc(32'($urandom_range(0, 20)));
      pick = int'($urandom_range(0, 9));
      v = mkVec(pick < 4 ? 2'd0 : pick < 8 ? 2'd1 : 2'($urandom_range(2, 3)),
                4'($urandom), 3'($urandom), 1'($urandom),
                ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom,
                32'($urandom_range(0, 20)), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 4)), 1'b0, 32'd0, 32'd0, 1'b0, 8'd0);
      predict(v);
      applyStimulus(v);
    end

    // acc_wr together with instr_vld: load wins, instruction taken the cycle after.
    @(negedge clk);
    acc_wr = 1'b1; acc_din = 32'd77; instr_vld = 1'b1;
    op_class = 2'd0; op_sel = 4'd0; jcond = 3'd0; src_x = 1'b0; imm = 32'd1;
    #1 checkOutput("rdy_acc_wr_vld", 32'(instr_rdy), 32'd0);
    @(negedge clk);
    acc_wr = 1'b0;
    #1 checkOutput("acc_wr_vld_acc", acc, 32'd77);
    checkOutput("acc_wr_vld_rdy", 32'(instr_rdy), 32'd1);
    @(negedge clk);
    instr_vld = 1'b0;
    #1 checkOutput("acc_wr_vld_en", 32'(ALU_en), 32'd1);
    checkOutput("acc_wr_vld_A", A, 32'd77);
    @(negedge clk);
    ALU_vld = 1'b1; ALU_out = 32'd78;
    #1 checkOutput("acc_wr_vld_done", 32'(done), 32'd1);
    @(negedge clk);
    ALU_vld = 1'b0;
    #1 checkOutput("acc_wr_vld_result", acc, 32'd78);
    accModel = 32'd78;

    // Reset while waiting on the ALU abandons the instruction.
    loadAcc(32'd20);
    ack0 = ackCount;
    @(negedge clk);
    instr_vld = 1'b1; op_class = 2'd0; op_sel = 4'd0; src_x = 1'b0; imm = 32'd4;
    #1 checkOutput("rst_case_rdy", 32'(instr_rdy), 32'd1);
    @(negedge clk);
    instr_vld = 1'b0;
    #1 checkOutput("rst_case_en", 32'(ALU_en), 32'd1);
    @(negedge clk);
    rst = 1'b1; ALU_vld = 1'b1; ALU_out = 32'd24;
    #1 checkOutput("rst_wait_done", 32'(done), 32'd0);
    checkOutput("rst_wait_ack", 32'(ALU_ack), 32'd0);
    checkOutput("rst_wait_rdy", 32'(instr_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0; ALU_vld = 1'b0;
    #1 checkOutput("rst_wait_acc", acc, 32'd0);
    checkOutput("rst_wait_done_after", 32'(done), 32'd0);
    checkOutput("rst_wait_rdy_after", 32'(instr_rdy), 32'd1);
    checkOutput("rst_wait_ack_count", 32'(ackCount - ack0), 32'd0);
    accModel = 32'd0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
